// File: rtl/wb_stage_param.sv
// Write-back stage: selects the write-back source, aligns and extends sub-word loads,
// flags misaligned loads, keeps a short commit history and counts retired instructions.
module wb_stage_param #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned HIST_DEPTH = 2,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned BIG_ENDIAN = 0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             stall,
   input  logic                             valid_mem_wb,
   input  logic                             ctrl_regWrite_mem_wb,
   input  logic [1:0]                       ctrl_wbSel_mem_wb,
   input  logic [1:0]                       ctrl_loadSize_mem_wb,
   input  logic                             ctrl_loadUnsigned_mem_wb,
   input  logic [REG_ADDR_W-1:0]            rd_addr_mem_wb,
   input  logic [31:0]                      alu_result_mem_wb,
   input  logic [31:0]                      read_data_from_mem_mem_wb,
   input  logic [31:0]                      pc_plus8_mem_wb,
   output logic [31:0]                      wb_data,
   output logic [REG_ADDR_W-1:0]            wb_rd_addr,
   output logic                             wb_reg_write,
   output logic                             misalign_err,
   output logic [HIST_DEPTH*32-1:0]         hist_data,
   output logic [HIST_DEPTH*REG_ADDR_W-1:0] hist_addr,
   output logic [HIST_DEPTH-1:0]            hist_valid,
   output logic [CNT_W-1:0]                 retired_count
);

   localparam logic BE = (BIG_ENDIAN != 0);

   logic [1:0]  off;
   logic [1:0]  lane;
   logic        hi_half;
   logic [7:0]  byte_val;
   logic [15:0] half_val;
   logic [31:0] load_val;
   logic [31:0] data_nxt;
   logic        misaligned;
   logic        write_nxt;
   logic        retire;

   logic [HIST_DEPTH-1:0][31:0]           hist_data_q;
   logic [HIST_DEPTH-1:0][REG_ADDR_W-1:0] hist_addr_q;

   assign hist_data = hist_data_q;
   assign hist_addr = hist_addr_q;

   // Lane extraction, extension and source select
   always_comb begin
      off     = alu_result_mem_wb[1:0];
      lane    = BE ? ~off : off;
      hi_half = off[1] ^ BE;

      case (lane)
         2'd0:    byte_val = read_data_from_mem_mem_wb[7:0];
         2'd1:    byte_val = read_data_from_mem_mem_wb[15:8];
         2'd2:    byte_val = read_data_from_mem_mem_wb[23:16];
         default: byte_val = read_data_from_mem_mem_wb[31:24];
      endcase
      half_val = hi_half ? read_data_from_mem_mem_wb[31:16] : read_data_from_mem_mem_wb[15:0];

      case (ctrl_loadSize_mem_wb)
         2'b00:   load_val = {{24{~ctrl_loadUnsigned_mem_wb & byte_val[7]}}, byte_val};
         2'b01:   load_val = {{16{~ctrl_loadUnsigned_mem_wb & half_val[15]}}, half_val};
         default: load_val = read_data_from_mem_mem_wb;
      endcase

      case (ctrl_wbSel_mem_wb)
         2'b01:   data_nxt = load_val;
         2'b10:   data_nxt = pc_plus8_mem_wb;
         default: data_nxt = alu_result_mem_wb;
      endcase

      misaligned = (ctrl_wbSel_mem_wb == 2'b01) &&
                   (((ctrl_loadSize_mem_wb == 2'b01) && off[0]) ||
                    (ctrl_loadSize_mem_wb[1] && (off != 2'b00)));
      write_nxt  = valid_mem_wb && ctrl_regWrite_mem_wb &&
                   (rd_addr_mem_wb != '0) && !misaligned;
      retire     = valid_mem_wb && !misaligned;
   end

   // Falling-edge state so decode sees the write on the following rising edge
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         wb_data       <= '0;
         wb_rd_addr    <= '0;
         wb_reg_write  <= 1'b0;
         misalign_err  <= 1'b0;
         hist_data_q   <= '0;
         hist_addr_q   <= '0;
         hist_valid    <= '0;
         retired_count <= '0;
      end else if (!stall) begin
         for (int unsigned k = 1; k < HIST_DEPTH; k++) begin
            hist_data_q[k] <= hist_data_q[k-1];
            hist_addr_q[k] <= hist_addr_q[k-1];
            hist_valid[k]  <= hist_valid[k-1];
         end
         hist_data_q[0] <= wb_data;
         hist_addr_q[0] <= wb_rd_addr;
         hist_valid[0]  <= wb_reg_write;

         wb_data       <= data_nxt;
         wb_rd_addr    <= rd_addr_mem_wb;
         wb_reg_write  <= write_nxt;
         misalign_err  <= valid_mem_wb && misaligned;
         retired_count <= retired_count + CNT_W'(retire);
      end
   end

endmodule

// File: tb/tb_wb_stage_param.sv
// Bench for wb_stage_param: a little-endian instance (depth 2, 4-bit counter) and a
// big-endian instance (depth 3, 32-bit counter) share stimulus and a behavioural model.
module tb_wb_stage_param;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        valid;
   logic        rw;
   logic [1:0]  sel;
   logic [1:0]  sz;
   logic        uns;
   logic [4:0]  rd;
   logic [31:0] alu;
   logic [31:0] mem;
   logic [31:0] pc8;

   logic [31:0] wd_a, wd_b;
   logic [4:0]  wa_a, wa_b;
   logic        ww_a, ww_b;
   logic        me_a, me_b;
   logic [63:0] hd_a;
   logic [95:0] hd_b;
   logic [9:0]  ha_a;
   logic [14:0] ha_b;
   logic [1:0]  hv_a;
   logic [2:0]  hv_b;
   logic [3:0]  cnt_a;
   logic [31:0] cnt_b;

   int n_vec = 0;
   int n_err = 0;

   wb_stage_param #(.REG_ADDR_W(5), .HIST_DEPTH(2), .CNT_W(4), .BIG_ENDIAN(0)) dut_a (
      .clk(clk), .reset(reset), .stall(stall), .valid_mem_wb(valid),
      .ctrl_regWrite_mem_wb(rw), .ctrl_wbSel_mem_wb(sel), .ctrl_loadSize_mem_wb(sz),
      .ctrl_loadUnsigned_mem_wb(uns), .rd_addr_mem_wb(rd), .alu_result_mem_wb(alu),
      .read_data_from_mem_mem_wb(mem), .pc_plus8_mem_wb(pc8),
      .wb_data(wd_a), .wb_rd_addr(wa_a), .wb_reg_write(ww_a), .misalign_err(me_a),
      .hist_data(hd_a), .hist_addr(ha_a), .hist_valid(hv_a), .retired_count(cnt_a));

   wb_stage_param #(.REG_ADDR_W(5), .HIST_DEPTH(3), .CNT_W(32), .BIG_ENDIAN(1)) dut_b (
      .clk(clk), .reset(reset), .stall(stall), .valid_mem_wb(valid),
      .ctrl_regWrite_mem_wb(rw), .ctrl_wbSel_mem_wb(sel), .ctrl_loadSize_mem_wb(sz),
      .ctrl_loadUnsigned_mem_wb(uns), .rd_addr_mem_wb(rd), .alu_result_mem_wb(alu),
      .read_data_from_mem_mem_wb(mem), .pc_plus8_mem_wb(pc8),
      .wb_data(wd_b), .wb_rd_addr(wa_b), .wb_reg_write(ww_b), .misalign_err(me_b),
      .hist_data(hd_b), .hist_addr(ha_b), .hist_valid(hv_b), .retired_count(cnt_b));

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   // Model state: index 0 = little-endian instance, 1 = big-endian instance
   logic [31:0] m_data [2];
   logic [4:0]  m_addr;
   logic        m_wr;
   logic        m_mis;
   int unsigned m_cnt;
   logic [31:0] m_hdata [2][8];
   logic [4:0]  m_haddr [8];
   logic        m_hvalid [8];

   function automatic logic [31:0] ref_data(input bit be);
      int          off;
      int          lane;
      int          hi;
      logic [31:0] v;
      off = int'(alu[1:0]);
      if (sel == 2'b10) return pc8;
      if (sel != 2'b01) return alu;
      if (sz >= 2'd2) return mem;
      if (sz == 2'd0) begin
         lane = be ? 3 - off : off;
         v = (mem >> (8 * lane)) & 32'hFF;
         if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else begin
         hi = be ? int'(off < 2) : int'(off >= 2);
         v = (mem >> (16 * hi)) & 32'hFFFF;
         if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic bit ref_misaligned();
      int off;
      off = int'(alu[1:0]);
      if (sel != 2'b01) return 1'b0;
      if (sz == 2'd1) return (off % 2) != 0;
      if (sz >= 2'd2) return off != 0;
      return 1'b0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         m_data[i] = '0;
         for (int k = 0; k < 8; k++) m_hdata[i][k] = '0;
      end
      for (int k = 0; k < 8; k++) begin
         m_haddr[k]  = '0;
         m_hvalid[k] = 1'b0;
      end
      m_addr = '0;
      m_wr   = 1'b0;
      m_mis  = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic model_step();
      bit mis;
      for (int k = 7; k > 0; k--) begin
         m_hdata[0][k] = m_hdata[0][k-1];
         m_hdata[1][k] = m_hdata[1][k-1];
         m_haddr[k]    = m_haddr[k-1];
         m_hvalid[k]   = m_hvalid[k-1];
      end
      m_hdata[0][0] = m_data[0];
      m_hdata[1][0] = m_data[1];
      m_haddr[0]    = m_addr;
      m_hvalid[0]   = m_wr;
      mis       = ref_misaligned();
      m_data[0] = ref_data(1'b0);
      m_data[1] = ref_data(1'b1);
      m_addr    = rd;
      m_wr      = valid && rw && (rd != 5'd0) && !mis;
      m_mis     = valid && mis;
      if (valid && !mis) m_cnt = m_cnt + 1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   task automatic check_all();
      chk("data_a", wd_a, m_data[0]);
      chk("data_b", wd_b, m_data[1]);
      chk("addr_a", 32'(wa_a), 32'(m_addr));
      chk("addr_b", 32'(wa_b), 32'(m_addr));
      chk("wr_a", 32'(ww_a), 32'(m_wr));
      chk("wr_b", 32'(ww_b), 32'(m_wr));
      chk("mis_a", 32'(me_a), 32'(m_mis));
      chk("mis_b", 32'(me_b), 32'(m_mis));
      chk("cnt_a", 32'(cnt_a), m_cnt % 16);
      chk("cnt_b", cnt_b, m_cnt);
      for (int k = 0; k < 2; k++) begin
         chk("hdata_a", hd_a[k*32 +: 32], m_hdata[0][k]);
         chk("haddr_a", 32'(ha_a[k*5 +: 5]), 32'(m_haddr[k]));
         chk("hvalid_a", 32'(hv_a[k]), 32'(m_hvalid[k]));
      end
      for (int k = 0; k < 3; k++) begin
         chk("hdata_b", hd_b[k*32 +: 32], m_hdata[1][k]);
         chk("haddr_b", 32'(ha_b[k*5 +: 5]), 32'(m_haddr[k]));
         chk("hvalid_b", 32'(hv_b[k]), 32'(m_hvalid[k]));
      end
   endtask

   // Model update and full comparison after every falling edge and every reset assertion
   always @(negedge clk or negedge reset) begin
      if (!reset) model_clear();
      else if (!stall) model_step();
      #1;
      check_all();
   end

   task automatic drive(input bit st, input bit v, input bit w, input logic [1:0] s,
                        input logic [1:0] z, input bit u, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] m, input logic [31:0] p);
      @(posedge clk);
      #1;
      stall = st; valid = v; rw = w; sel = s; sz = z; uns = u;
      rd = r; alu = a; mem = m; pc8 = p;
      @(negedge clk);
      #2;
   endtask

   task automatic drive_rand(input bit allow_stall);
      bit st;
      st = allow_stall && ($urandom_range(0, 9) == 0);
      drive(st, 1'($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #3;
      reset = 1'b0;
      #2;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; valid = 1'b0; rw = 1'b0; sel = 2'b00; sz = 2'b00;
      uns = 1'b0; rd = '0; alu = '0; mem = '0; pc8 = '0;
      @(negedge clk);
      #2;
      chk("reset_data", wd_a, 32'h0);
      chk("reset_cnt", 32'(cnt_a), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // ALU path
      drive(0, 1, 1, 2'b00, 2'b10, 0, 5'd5, 32'h0000_1234, 32'h0, 32'h0);
      chk("alu_data", wd_a, 32'h0000_1234);
      chk("alu_wr", 32'(ww_a), 32'h1);
      chk("alu_cnt", 32'(cnt_a), 32'h1);

      // Sub-word loads, mem = 80FF_7F81
      drive(0, 1, 1, 2'b01, 2'b00, 0, 5'd6, 32'h0000_1000, 32'h80FF_7F81, 32'h0);
      chk("lb_off0_le", wd_a, 32'hFFFF_FF81);
      drive(0, 1, 1, 2'b01, 2'b00, 1, 5'd6, 32'h0000_1003, 32'h80FF_7F81, 32'h0);
      chk("lbu_off3_le", wd_a, 32'h0000_0080);
      chk("lbu_off3_be", wd_b, 32'h0000_0081);
      drive(0, 1, 1, 2'b01, 2'b01, 0, 5'd6, 32'h0000_1002, 32'h80FF_7F81, 32'h0);
      chk("lh_off2_le", wd_a, 32'hFFFF_80FF);

      // Misaligned word load, then an aligned one
      drive(0, 1, 1, 2'b01, 2'b10, 0, 5'd7, 32'h0000_1002, 32'hCAFE_F00D, 32'h0);
      chk("mis_flag", 32'(me_a), 32'h1);
      chk("mis_wr", 32'(ww_a), 32'h0);
      chk("mis_cnt", 32'(cnt_a), 32'h4);
      drive(0, 1, 1, 2'b01, 2'b10, 0, 5'd7, 32'h0000_1000, 32'hCAFE_F00D, 32'h0);
      chk("lw_clear", 32'(me_a), 32'h0);
      chk("lw_cnt", 32'(cnt_a), 32'h5);

      // Link path with rd=0 and rd=31
      drive(0, 1, 1, 2'b10, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0040_0008);
      chk("jal_r0_wr", 32'(ww_a), 32'h0);
      chk("jal_r0_cnt", 32'(cnt_a), 32'h6);
      drive(0, 1, 1, 2'b10, 2'b00, 0, 5'd31, 32'h0, 32'h0, 32'h0040_0008);
      chk("jal_r31", wd_a, 32'h0040_0008);

      // History: r1, r2, r3, then a bubble
      for (int i = 1; i <= 3; i++)
         drive(0, 1, 1, 2'b00, 2'b10, 0, 5'(i), 32'(100 + i), 32'h0, 32'h0);
      drive(0, 0, 0, 2'b00, 2'b10, 0, 5'd9, 32'h0, 32'h0, 32'h0);
      chk("hist_addr0", 32'(ha_a[4:0]), 32'd3);
      chk("hist_addr1", 32'(ha_a[9:5]), 32'd2);
      chk("hist_valid", 32'(hv_a), 32'h3);
      chk("hist_data0", hd_a[31:0], 32'd103);

      // Stall for three edges with junk inputs
      for (int i = 0; i < 3; i++)
         drive(1, 1, 1, 2'b00, 2'b00, 0, 5'd17, $urandom, $urandom, $urandom);
      chk("stall_addr", 32'(wa_a), 32'd9);
      chk("stall_cnt", 32'(cnt_b), 32'd10);

      // Reset between edges while stalled; release mid-stall
      @(posedge clk);
      #3;
      reset = 1'b0;
      #2;
      chk("async_rst_addr", 32'(wa_a), 32'h0);
      chk("async_rst_hv", 32'(hv_b), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(1, 1, 1, 2'b00, 2'b00, 0, 5'd4, 32'h55, 32'h0, 32'h0);
      chk("rst_stall_data", wd_a, 32'h0);

      // Sixteen retires wrap the 4-bit counter
      for (int i = 0; i < 16; i++)
         drive(0, 1, 1, 2'b00, 2'b00, 0, 5'd8, 32'(i), 32'h0, 32'h0);
      chk("wrap_cnt_a", 32'(cnt_a), 32'h0);
      chk("wrap_cnt_b", cnt_b, 32'd16);

      // Randomised traffic with occasional stalls and resets
      for (int i = 0; i < 400; i++) begin
         drive_rand(1'b1);
         if (i % 131 == 130) pulse_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
